// File: rtl/fc8_vram_arb.sv
// Single-port video RAM shared by one CPU port, NVID video read channels and a
// whole-array clear engine; all arbitration is resolved combinationally each cycle.
module fc8_vram_arb #(
  parameter int                AWIDTH     = 16,
  parameter int                DWIDTH     = 8,
  parameter int                SIZE       = 1 << AWIDTH,
  parameter int                NVID       = 2,
  parameter int                STARVE_MAX = 4,
  parameter logic [DWIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [AWIDTH-1:0]      cpu_addr,
  input  logic [DWIDTH-1:0]      cpu_wdata,
  output logic                   cpu_ack,
  output logic                   cpu_rvalid,
  output logic [DWIDTH-1:0]      cpu_rdata,
  input  logic [NVID-1:0]        vid_req,
  input  logic [NVID*AWIDTH-1:0] vid_addr,
  output logic [NVID-1:0]        vid_ack,
  output logic [NVID-1:0]        vid_rvalid,
  output logic [NVID*DWIDTH-1:0] vid_rdata,
  input  logic                   clear_start,
  output logic                   clear_busy,
  output logic                   clear_done,
  output logic                   dbg_clear_state
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int RW = (NVID > 1) ? $clog2(NVID) : 1;
  localparam int WW = $clog2(STARVE_MAX + 1);
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(SIZE - 1);

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} clr_state_t;

  // Handshake: a requester holds req (and its address/data) until it sees ack in
  // the same cycle; the access happens at that edge and read data comes back
  // with a one-cycle rvalid pulse on the following cycle.

  logic [DWIDTH-1:0] mem [SIZE];

  clr_state_t        state, state_nxt;
  logic [AWIDTH-1:0] cnt;
  logic [RW-1:0]     rr;
  logic [WW-1:0]     wait_cnt;
  logic              starved;
  logic              vid_hit;
  logic [RW-1:0]     vid_sel;
  logic [RW-1:0]     cand;
  logic [AWIDTH-1:0] acc_addr;
  logic              in_range;
  logic [DWIDTH-1:0] rd_word;

  assign starved         = (wait_cnt == WW'(STARVE_MAX));
  assign clear_busy      = (state == S_FILL);
  assign dbg_clear_state = state;

  // First requesting channel at or after rr.
  always_comb begin
    vid_hit = 1'b0;
    vid_sel = '0;
    cand    = '0;
    for (int i = 0; i < NVID; i++) begin
      cand = RW'((int'(rr) + i) % NVID);
      if (!vid_hit && vid_req[cand]) begin
        vid_hit = 1'b1;
        vid_sel = cand;
      end
    end
  end

  always_comb begin
    cpu_ack   = 1'b0;
    vid_ack   = '0;
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!rst) begin
          if (cpu_req && starved)  cpu_ack = 1'b1;
          else if (vid_hit)        vid_ack[vid_sel] = 1'b1;
          else if (cpu_req)        cpu_ack = 1'b1;
        end
        if (clear_start) state_nxt = S_FILL;
      end
      S_FILL: begin
        if (cnt == LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign acc_addr = cpu_ack ? cpu_addr : vid_addr[vid_sel*AWIDTH +: AWIDTH];
  assign in_range = ({1'b0, acc_addr} < (AWIDTH+1)'(SIZE));
  assign rd_word  = in_range ? mem[acc_addr[IW-1:0]] : '0;

  // Array contents survive reset; only the fill engine clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_FILL)
        mem[cnt[IW-1:0]] <= FILL_VALUE;
      else if (cpu_ack && cpu_we && in_range)
        mem[acc_addr[IW-1:0]] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rr         <= '0;
      wait_cnt   <= '0;
      clear_done <= 1'b0;
      cpu_rvalid <= 1'b0;
      vid_rvalid <= '0;
      cpu_rdata  <= '0;
      vid_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      clear_done <= (state == S_FILL) && (cnt == LAST);
      cnt        <= (state == S_FILL) ? cnt + 1'b1 : '0;

      if (|vid_ack)
        rr <= (vid_sel == RW'(NVID - 1)) ? '0 : vid_sel + 1'b1;

      if (!cpu_req || cpu_ack)  wait_cnt <= '0;
      else if (!starved)        wait_cnt <= wait_cnt + 1'b1;

      cpu_rvalid <= cpu_ack && !cpu_we;
      if (cpu_ack && !cpu_we) cpu_rdata <= rd_word;

      vid_rvalid <= vid_ack;
      for (int i = 0; i < NVID; i++)
        if (vid_ack[i]) vid_rdata[i*DWIDTH +: DWIDTH] <= rd_word;
    end
  end

endmodule

// File: tb/tb_fc8_vram_arb.sv
// Bench for fc8_vram_arb: table-driven vectors, hand-written clear/reset corners
// and constrained-random traffic, all scored against a cycle-level reference model.
module tb_fc8_vram_arb;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SZ = 256;
  localparam int NV = 2;
  localparam int SM = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cpu_req, cpu_we;
  logic [AW-1:0]    cpu_addr;
  logic [DW-1:0]    cpu_wdata;
  logic             cpu_ack, cpu_rvalid;
  logic [DW-1:0]    cpu_rdata;
  logic [NV-1:0]    vid_req;
  logic [NV*AW-1:0] vid_addr;
  logic [NV-1:0]    vid_ack, vid_rvalid;
  logic [NV*DW-1:0] vid_rdata;
  logic             clear_start, clear_busy, clear_done, dbg_clear_state;

  fc8_vram_arb #(.AWIDTH(AW), .DWIDTH(DW), .SIZE(SZ), .NVID(NV),
                 .STARVE_MAX(SM), .FILL_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .dbg_clear_state(dbg_clear_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  int            m_rr, m_wait, m_cnt;
  bit            m_fill, m_done, m_cpu_rv;
  logic [NV-1:0] m_vid_rv;
  logic [DW-1:0] m_cpu_rd;
  logic [DW-1:0] m_vid_rd [NV];
  logic [DW-1:0] m_mem [SZ];
  logic [DW-1:0] exp_q [$];
  logic          e_cpu_ack;
  logic [NV-1:0] e_vid_ack;
  int            e_vid_ch;

  logic          s_busy, s_done, s_cpu_rvalid;
  logic [DW-1:0] s_cpu_rdata;

  typedef struct {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [NV-1:0] vreq;
    logic          exp_cpu;
    logic [NV-1:0] exp_vid;
  } vec_t;
  vec_t tab [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int a);
    return (a < SZ) ? m_mem[a] : '0;
  endfunction

  task automatic model_eval();
    e_cpu_ack = 1'b0;
    e_vid_ch  = -1;
    if (!rst && !m_fill) begin
      if (cpu_req && m_wait == SM) e_cpu_ack = 1'b1;
      else begin
        for (int k = 0; k < NV; k++)
          if (e_vid_ch < 0 && vid_req[(m_rr + k) % NV]) e_vid_ch = (m_rr + k) % NV;
        if (e_vid_ch < 0 && cpu_req) e_cpu_ack = 1'b1;
      end
    end
    e_vid_ack = '0;
    if (e_vid_ch >= 0) e_vid_ack[e_vid_ch] = 1'b1;
  endtask

  task automatic model_commit();
    int a;
    if (rst) begin
      m_rr = 0; m_wait = 0; m_cnt = 0;
      m_fill = 0; m_done = 0; m_cpu_rv = 0; m_vid_rv = '0;
      m_cpu_rd = '0;
      for (int c = 0; c < NV; c++) m_vid_rd[c] = '0;
      exp_q.delete();
      return;
    end
    m_cpu_rv = 0; m_vid_rv = '0; m_done = 0;
    if (e_cpu_ack) begin
      if (cpu_we) begin
        if (int'(cpu_addr) < SZ) m_mem[int'(cpu_addr)] = cpu_wdata;
      end else begin
        exp_q.push_back(model_read(int'(cpu_addr)));
        m_cpu_rv = 1;
      end
    end
    if (e_vid_ch >= 0) begin
      a = int'(vid_addr[e_vid_ch*AW +: AW]);
      m_vid_rd[e_vid_ch] = model_read(a);
      m_vid_rv[e_vid_ch] = 1'b1;
      m_rr = (e_vid_ch + 1) % NV;
    end
    m_wait = (cpu_req && !e_cpu_ack) ? ((m_wait < SM) ? m_wait + 1 : SM) : 0;
    if (m_fill) begin
      m_mem[m_cnt] = 8'h00;
      if (m_cnt == SZ - 1) begin m_fill = 0; m_done = 1; end
      m_cnt++;
    end else if (clear_start) begin
      m_fill = 1; m_cnt = 0;
    end
  endtask

  // Scoreboard: compare every observable output against the model
  task automatic check_outputs();
    check("cpu_ack", cpu_ack, e_cpu_ack);
    check("vid_ack", vid_ack, e_vid_ack);
    check("clear_busy", clear_busy, m_fill);
    check("clear_done", clear_done, m_done);
    check("cpu_rvalid", cpu_rvalid, m_cpu_rv);
    check("vid_rvalid", vid_rvalid, m_vid_rv);
    if (m_cpu_rv) begin
      check("cpu_exp_q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) m_cpu_rd = exp_q.pop_front();
    end
    check("cpu_rdata", cpu_rdata, m_cpu_rd);
    for (int c = 0; c < NV; c++)
      check($sformatf("vid_rdata%0d", c), vid_rdata[c*DW +: DW], m_vid_rd[c]);
  endtask

  // Driver: one clock cycle with current inputs
  task automatic step(input bit tab_chk, input logic t_cpu, input logic [NV-1:0] t_vid);
    model_eval();
    @(negedge clk);
    s_busy = clear_busy; s_done = clear_done;
    s_cpu_rvalid = cpu_rvalid; s_cpu_rdata = cpu_rdata;
    if (chk_en) check_outputs();
    if (tab_chk) begin
      check("tab_cpu_ack", cpu_ack, t_cpu);
      check("tab_vid_ack", vid_ack, t_vid);
    end
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = '0; clear_start = 0;
  endtask

  task automatic cpu_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
  endtask

  task automatic wait_clear_done(output int busy_n, output bit done);
    busy_n = 0; done = 0;
    for (int j = 0; j < 400; j++) begin
      step(0, 0, '0);
      if (s_busy) busy_n++;
      if (s_done) begin done = 1; break; end
    end
  endtask

  initial begin
    int  busy_n;
    bit  done;

    for (int i = 0; i < SZ; i++) m_mem[i] = '0;
    rst = 1; set_idle(); vid_addr = '0;
    @(posedge clk); #1;
    step(0, 0, '0);
    chk_en = 1;
    step(0, 0, '0);
    check("rst_busy", s_busy, 0);
    check("rst_cpu_rdata", s_cpu_rdata, 0);
    rst = 0;

    // Initialise the array through the clear engine
    clear_start = 1; step(0, 0, '0); clear_start = 0;
    wait_clear_done(busy_n, done);
    check("init_clr_busy_cycles", busy_n, SZ);
    check("init_clr_done", done, 1);

    // Table-driven arbitration vectors (rr=0, wait_cnt=0 here)
    vid_addr = {16'h0011, 16'h0010};
    tab.push_back(vec_t'{1, 1, 16'h0010, 8'hA5, 2'b00, 1, 2'b00});
    tab.push_back(vec_t'{1, 0, 16'h0010, 8'h00, 2'b00, 1, 2'b00});
    tab.push_back(vec_t'{0, 0, 16'h0000, 8'h00, 2'b00, 0, 2'b00});
    tab.push_back(vec_t'{0, 0, 16'h0000, 8'h00, 2'b11, 0, 2'b01});
    tab.push_back(vec_t'{0, 0, 16'h0000, 8'h00, 2'b11, 0, 2'b10});
    tab.push_back(vec_t'{0, 0, 16'h0000, 8'h00, 2'b11, 0, 2'b01});
    tab.push_back(vec_t'{0, 0, 16'h0000, 8'h00, 2'b10, 0, 2'b10});
    tab.push_back(vec_t'{0, 0, 16'h0000, 8'h00, 2'b01, 0, 2'b01});
    tab.push_back(vec_t'{0, 0, 16'h0000, 8'h00, 2'b01, 0, 2'b01});
    tab.push_back(vec_t'{1, 0, 16'h0010, 8'h00, 2'b11, 0, 2'b10});
    tab.push_back(vec_t'{1, 0, 16'h0010, 8'h00, 2'b11, 0, 2'b01});
    tab.push_back(vec_t'{1, 0, 16'h0010, 8'h00, 2'b11, 0, 2'b10});
    tab.push_back(vec_t'{1, 0, 16'h0010, 8'h00, 2'b11, 0, 2'b01});
    tab.push_back(vec_t'{1, 0, 16'h0010, 8'h00, 2'b11, 1, 2'b00});
    tab.push_back(vec_t'{1, 0, 16'h0010, 8'h00, 2'b11, 0, 2'b10});
    tab.push_back(vec_t'{0, 0, 16'h0000, 8'h00, 2'b00, 0, 2'b00});
    tab.push_back(vec_t'{1, 0, 16'h0100, 8'h00, 2'b00, 1, 2'b00});
    tab.push_back(vec_t'{1, 1, 16'h0100, 8'h77, 2'b00, 1, 2'b00});
    tab.push_back(vec_t'{1, 0, 16'h0000, 8'h00, 2'b00, 1, 2'b00});
    tab.push_back(vec_t'{1, 0, 16'h0100, 8'h00, 2'b00, 1, 2'b00});
    tab.push_back(vec_t'{0, 0, 16'h0000, 8'h00, 2'b00, 0, 2'b00});
    foreach (tab[i]) begin
      cpu_req = tab[i].req; cpu_we = tab[i].we;
      cpu_addr = tab[i].addr; cpu_wdata = tab[i].wd; vid_req = tab[i].vreq;
      step(1, tab[i].exp_cpu, tab[i].exp_vid);
      if (i == 2) begin
        check("rd_a5_rvalid", s_cpu_rvalid, 1);
        check("rd_a5_rdata", s_cpu_rdata, 8'hA5);
      end
      if (i == 20) check("oob_wr_rd0", s_cpu_rdata, 8'h00);
    end

    // Clear with traffic: read acked in the clear_start cycle completes in FILL
    set_idle();
    cpu_op(1, 16'h0003, 8'h5A); step(0, 0, '0);
    cpu_op(0, 16'h0003, 8'h00); clear_start = 1; step(0, 0, '0);
    clear_start = 0; vid_req = 2'b11; cpu_op(0, 16'h0004, 8'h00);
    step(0, 0, '0);
    check("pend_rd_rvalid", s_cpu_rvalid, 1);
    check("pend_rd_rdata", s_cpu_rdata, 8'h5A);
    wait_clear_done(busy_n, done);
    check("clr_busy_cycles", busy_n + 1, SZ);
    check("clr_done", done, 1);
    set_idle();
    cpu_op(0, 16'h0003, 8'h00); step(0, 0, '0);
    set_idle(); step(0, 0, '0);
    check("clr_rd_zero", s_cpu_rdata, 8'h00);

    // Reset ten cycles into a fill
    cpu_op(1, 16'h0005, 8'h11); step(0, 0, '0);
    cpu_op(1, 16'h000A, 8'h22); step(0, 0, '0);
    cpu_op(1, 16'h0014, 8'h33); step(0, 0, '0);
    set_idle(); clear_start = 1; step(0, 0, '0);
    clear_start = 0;
    for (int k = 0; k < 10; k++) step(0, 0, '0);
    rst = 1; step(0, 0, '0);
    rst = 0; step(0, 0, '0);
    check("rstfill_busy", s_busy, 0);
    check("rstfill_rdata", s_cpu_rdata, 8'h00);
    cpu_op(0, 16'h0005, 8'h00); step(0, 0, '0); set_idle(); step(0, 0, '0);
    check("rstfill_a5", s_cpu_rdata, 8'h00);
    cpu_op(0, 16'h000A, 8'h00); step(0, 0, '0); set_idle(); step(0, 0, '0);
    check("rstfill_a10", s_cpu_rdata, 8'h22);
    cpu_op(0, 16'h0014, 8'h00); step(0, 0, '0); set_idle(); step(0, 0, '0);
    check("rstfill_a20", s_cpu_rdata, 8'h33);

    // Randomised traffic; CPU request fields held until acked
    for (int n = 0; n < 600; n++) begin
      if (!cpu_req || e_cpu_ack) begin
        cpu_req   = ($urandom_range(0, 99) < 60);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'($urandom_range(0, 511));
        cpu_wdata = 8'($urandom_range(0, 255));
      end
      vid_req     = 2'($urandom_range(0, 3));
      vid_addr    = {16'($urandom_range(0, 511)), 16'($urandom_range(0, 511))};
      clear_start = ($urandom_range(0, 299) == 0);
      step(0, 0, '0);
    end
    set_idle();
    for (int k = 0; k < 300 && m_fill; k++) step(0, 0, '0);
    step(0, 0, '0); step(0, 0, '0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fc8_vram_arb.md
FC8_VRAM_ARB -- requirements
Module: fc8_vram_arb

Interface
REQ-001 SHALL have parameter AWIDTH, default 16, meaning address width.
REQ-002 SHALL have parameter DWIDTH, default 8, meaning data width.
REQ-003 SHALL have parameter SIZE, default 1<<AWIDTH, meaning implemented words (1..2^AWIDTH).
REQ-004 SHALL have parameter NVID, default 2, meaning video read channels (1..8).
REQ-005 SHALL have parameter STARVE_MAX, default 4, meaning max consecutive denied CPU cycles (1..255).
REQ-006 SHALL have parameter FILL_VALUE, default 0, meaning DWIDTH-bit clear pattern.
REQ-007 SHALL have port clk  in  1  sole clock, all logic on posedge.
REQ-008 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-009 SHALL have port cpu_req  in  1  CPU access request, held until acked.
REQ-010 SHALL have port cpu_we  in  1  1=write, 0=read; stable while cpu_req high.
REQ-011 SHALL have port cpu_addr  in  AWIDTH  CPU address.
REQ-012 SHALL have port cpu_wdata  in  DWIDTH  CPU write data.
REQ-013 SHALL have port cpu_ack  out  1  CPU grant, same cycle as array access.
REQ-014 SHALL have port cpu_rvalid  out  1  CPU read data valid.
REQ-015 SHALL have port cpu_rdata  out  DWIDTH  CPU read data.
REQ-016 SHALL have port vid_req  in  NVID  per-channel read request.
REQ-017 SHALL have port vid_addr  in  NVID*AWIDTH  channel i address in bits [i*AWIDTH +: AWIDTH].
REQ-018 SHALL have port vid_ack  out  NVID  per-channel grant.
REQ-019 SHALL have port vid_rvalid  out  NVID  per-channel read data valid.
REQ-020 SHALL have port vid_rdata  out  NVID*DWIDTH  channel i data in bits [i*DWIDTH +: DWIDTH].
REQ-021 SHALL have port clear_start  in  1  pulse to begin fill of whole array.
REQ-022 SHALL have port clear_busy  out  1  fill in progress.
REQ-023 SHALL have port clear_done  out  1  one-cycle pulse at fill completion.

Function
REQ-024 Storage SHALL be one single-port array of SIZE x DWIDTH; at most one access per cycle.
REQ-025 Acks SHALL be combinational from requests and registered arbiter state; exactly zero or one of cpu_ack/vid_ack high per cycle.
REQ-026 Priority: clear engine > starved CPU > video round-robin > CPU.
REQ-027 Video round-robin: grant first requesting channel at or after pointer rr; rr <= (granted+1) mod NVID on video grant, else unchanged.
REQ-028 Starvation counter wait_cnt: increments each cycle cpu_req=1 and cpu_ack=0, saturating at STARVE_MAX; clears on cpu_ack or cpu_req=0.
REQ-029 CPU SHALL be "starved" when wait_cnt==STARVE_MAX; then CPU wins over all video requests.
REQ-030 Read latency: rvalid and rdata of the granted requester SHALL assert exactly 1 cycle after ack, for one cycle.
REQ-031 rdata SHALL hold last value when rvalid=0.
REQ-032 CPU write SHALL update array at ack edge; cpu_rvalid not asserted for writes.
REQ-033 Address >= SIZE: read returns 0 with normal rvalid timing; write is dropped; both still acked.
REQ-034 Clear FSM states IDLE, FILL: IDLE->FILL on clear_start; FILL writes FILL_VALUE to address cnt, cnt 0..SIZE-1, one per cycle; FILL->IDLE after writing SIZE-1, clear_done pulses the cycle after last write.
REQ-035 clear_busy SHALL be 1 exactly in FILL; all acks 0 while in FILL; clear_start in FILL ignored.
REQ-036 clear_start and requests in same IDLE cycle: requests arbitrated normally that cycle, FILL starts next cycle.
REQ-037 Read pending in rvalid stage when FILL begins SHALL still complete.

Reset
REQ-038 On rst: rr=0, wait_cnt=0, FSM=IDLE, cnt=0; all acks, rvalid, clear_busy, clear_done = 0; cpu_rdata and vid_rdata = 0.
REQ-039 Array contents SHALL NOT be altered by rst; clearing is via clear engine only.
REQ-040 rst during FILL SHALL abort fill immediately; in-flight rvalid suppressed.

Verification
REQ-041 CPU write 0xA5 to 0x0010, later read 0x0010 with no video req -> ack same cycle, rvalid+rdata=0xA5 next cycle.
REQ-042 vid_req=2'b11 held, rr=0 -> vid_ack alternates 01,10,01...; each rvalid 1 cycle after matching ack.
REQ-043 vid_req=2'b11 and cpu_req held, STARVE_MAX=4 -> cpu_ack on 5th cycle, wait_cnt back to 0.
REQ-044 clear_start with SIZE=256 -> clear_busy 256 cycles, no acks, clear_done pulse, then any read returns 0x00.
REQ-045 SIZE=256, CPU write 0x77 to 0x0100 then read 0x0100 -> both acked, rdata=0x00, address 0x00 unchanged.
REQ-046 rst at FILL cnt=10 -> next cycle clear_busy=0, outputs at reset values, addresses >=10 keep old contents.
